// File: rtl/priority_encoder4to2_irq.sv
// Registered 4-to-2 priority encoder with per-line pending latches and a valid/ack handshake.
// Line 3 has the highest priority. A presented code is frozen until it is acknowledged.
module priority_encoder4to2_irq (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic       i_ack,
  output logic       o_valid,
  output logic [1:0] o_code,
  output logic [3:0] o_pending
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_pending;
  logic [3:0] w_pending_next;
  logic [3:0] w_clr;
  logic [1:0] r_code;
  logic [1:0] w_code_next;
  logic [1:0] w_enc;
  logic       r_valid;
  logic       w_valid_next;

  // Retire only the presented line; a request on that same line in the ack cycle re-arms it.
  always_comb begin
    w_clr = 4'b0000;
    if (r_valid && i_ack) begin
      w_clr = 4'b0001 << r_code;
    end
    w_pending_next = i_req | (r_pending & ~w_clr);
  end

  assign w_enc = {r_pending[3] | r_pending[2],
                  r_pending[3] | (~r_pending[2] & r_pending[1])};

  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_valid_next = r_valid;
    case (r_state)
      ST_IDLE: begin
        if (r_pending != 4'b0000) begin
          w_code_next  = w_enc;
          w_valid_next = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_ack) begin
          w_valid_next = 1'b0;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_valid_next = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_pending <= 4'b0000;
      r_code    <= 2'b00;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      r_code    <= w_code_next;
      r_valid   <= w_valid_next;
    end
  end

  assign o_valid   = r_valid;
  assign o_code    = r_code;
  assign o_pending = r_pending;

endmodule

// File: doc/priority_encoder4to2_irq.md
# priority_encoder4to2_irq

Registered 4-to-2 priority encoder with per-line pending latches and a valid/ack handshake. It collects up to four one-cycle or level request lines and presents the highest-priority pending line as a 2-bit code. The consumer, the CPU control path, acknowledges each code, and the encoder then retires that line. It is the encode-side counterpart of the 2-to-4 line decoder and sits between peripheral request lines and the control unit's interrupt/select input.

## Interface
Parameters: none (width fixed at 4 lines / 2-bit code).
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk
- req  input  4  request lines; req[i]=1 in any cycle marks line i pending
- ack  input  1  consumer acknowledge of the currently presented code; ignored when valid=0
- valid  output  1  code holds a presented request awaiting ack
- code  output  2  index of presented line; line 3 is highest priority, line 0 lowest
- pending  output  4  current pending latch contents, registered

## Operation
- State per line: pending[i] flop. Control state: IDLE (valid=0) or HOLD (valid=1).
- Pending update each edge, when rst=0:
  - pending[i]_next = req[i] | (pending[i] & ~clr[i])
  - clr[i] = valid & ack & (code == i)
  - Set wins: if req[i] and clr[i] occur in the same cycle, pending[i] stays 1 and the line is served again later.
- IDLE: if pending (registered value) != 0 at the edge:
  - code <= index of highest set bit of pending
  - valid <= 1
  - go to HOLD
  - Otherwise remain in IDLE with code unchanged.
- HOLD:
  - code and valid are frozen until ack=1.
  - Higher-priority requests arriving during HOLD do not preempt. They are latched and served after the current ack.
  - On ack=1 at the edge: valid <= 0, pending[code] cleared per the rule above, go to IDLE.
- Back-to-back: the cycle after an ack always shows valid=0, a mandatory one-cycle gap. The next capture happens on the following edge if anything is pending.
- code holds its last value while valid=0. Consumers must qualify code with valid.
- Encoding function: code = {p3 | p2, p3 | (~p2 & p1)} over the registered pending bits.
- Reset (rst=1 at an edge):
  - Forces pending=0000, valid=0, code=00, state IDLE.
  - Takes priority over req and ack in the same cycle.
  - Reset mid-HOLD discards the presented request and all pending lines.

## Timing
- Request latency:
  - req[i] high at edge k → pending[i]=1 after edge k.
  - valid=1 and code=i after edge k+1 if idle and i is the highest pending line.
  - Total: 2 cycles from req sample to valid.
- Ack latency: ack high at edge m → valid=0 and pending[code]=0 after edge m.
- Earliest next valid is after edge m+1.
- Minimum service period per request: 2 cycles (capture + ack), with ack held high continuously.
- All outputs are registered; there is no combinational path from req or ack to any output.
- A one-cycle req pulse is never lost. Holding req high for multiple cycles is equivalent to one request, except that it re-arms the line if still high during its own ack.

## Test plan
- Reset:
  - Stimulus: rst=1 for 2 cycles with req=1111, ack=1.
  - Required: pending=0000, valid=0, code=00 after the reset edge.
  - After rst falls with req=0000, outputs stay at those values.
- Single request:
  - Stimulus: req=0100 for one cycle at edge k.
  - Required: pending=0100 after k; valid=1, code=10 after k+1.
  - Hold ack=0 for 5 cycles: code stays 10 and valid stays 1.
  - Ack: valid=0, pending=0000 on the next edge.
- Priority and ordering:
  - Stimulus: req=1011 pulsed once; ack held at 1 from then on.
  - Required codes presented: 11, then 01, then 00.
  - Each code separated by exactly one valid=0 cycle.
  - Ends with pending=0000.
- No preemption:
  - Stimulus: while presenting code=00 (pending=0001), pulse req=1000; ack=0.
  - Required: code stays 00 and pending becomes 1001.
  - After ack, the next presented code is 11.
- Set-wins collision:
  - Stimulus: presenting code=10, ack=1 and req=0100 in the same cycle.
  - Required: valid=0 for one cycle, pending=0100 retained, then valid=1 and code=10 again.
- Reset mid-operation:
  - Stimulus: valid=1, code=11, pending=1110, then assert rst with ack=1.
  - Required: pending=0000, valid=0, code=00; no stale code re-presented afterwards.
